// File: rtl/ahb_wrr_arbiter.sv
// Weighted round-robin AHB arbiter for four masters. Tracks bursts and locked
// sequences and spends per-master credits so tenures follow programmed weights.
module ahb_wrr_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned WEIGHT_W       = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                            Hclk,
  input  logic                            Hresetn,
  input  logic [N_MASTERS-1:0]            Hreq,
  input  logic [N_MASTERS-1:0]            Hlock,
  input  logic                            Hready,
  input  logic [1:0]                      Htrans,
  input  logic [2:0]                      Hburst,
  input  logic [N_MASTERS*WEIGHT_W-1:0]   cfg_weight,
  output logic [N_MASTERS-1:0]            Hgrant,
  output logic [$clog2(N_MASTERS)-1:0]    Hmaster,
  output logic [$clog2(N_MASTERS)-1:0]    Hmaster_data,
  output logic                            Hmastlock
);

  localparam int unsigned IDX_W = $clog2(N_MASTERS);
  localparam logic [IDX_W-1:0]     DEF_IDX = IDX_W'(DEFAULT_MASTER);
  localparam logic [N_MASTERS-1:0] GNT_RST = N_MASTERS'(1) << DEFAULT_MASTER;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {BUS_IDLE, FIXED_BURST, INCR_BURST, LOCKED} state_e;

  state_e                              state_q, state_d;
  logic [3:0]                          cnt_q, cnt_d;
  logic [N_MASTERS-1:0][WEIGHT_W-1:0]  credit_q, credit_d;
  logic [N_MASTERS-1:0][WEIGHT_W-1:0]  w_eff;
  logic [N_MASTERS-1:0]                hgrant_q, hgrant_d;
  logic [IDX_W-1:0]                    gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]                    hmaster_q, hmaster_d;
  logic [IDX_W-1:0]                    hmaster_data_q, hmaster_data_d;
  logic                                hmastlock_q, hmastlock_d;

  logic acc_nonseq, acc_seq, idle_done;
  logic handover, any_req, any_cand, reload, consume, found;
  logic [N_MASTERS-1:0] cand;
  logic [IDX_W-1:0]     sel, idx;

  assign acc_nonseq = Hready && (Htrans == TR_NONSEQ);
  assign acc_seq    = Hready && (Htrans == TR_SEQ);
  assign idle_done  = Hready && (Htrans == TR_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (acc_nonseq && Hlock[hmaster_q]) begin
      state_d = LOCKED;
    end else if (acc_nonseq) begin
      case (Hburst)
        3'b000:  state_d = BUS_IDLE;
        3'b001:  state_d = INCR_BURST;
        default: begin
          state_d = FIXED_BURST;
          case (Hburst[2:1])
            2'b01:   cnt_d = 4'd3;
            2'b10:   cnt_d = 4'd7;
            default: cnt_d = 4'd15;
          endcase
        end
      endcase
    end else begin
      case (state_q)
        FIXED_BURST: begin
          if (acc_seq) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = BUS_IDLE;
          end else if (idle_done) begin
            state_d = BUS_IDLE;
            cnt_d   = '0;
          end
        end
        INCR_BURST: if (idle_done) state_d = BUS_IDLE;
        LOCKED:     if (!Hlock[hmaster_q] && idle_done) state_d = BUS_IDLE;
        default:    ;
      endcase
    end
  end

  assign handover = ((state_q == BUS_IDLE) && !acc_nonseq) ||
                    ((state_q == FIXED_BURST) && (cnt_q == 4'd1) && acc_seq) ||
                    ((state_q == INCR_BURST) && !Hreq[hmaster_q]);

  // Round-robin from Hmaster+1 over credited requesters, or over all
  // requesters when every requester is out of credit (that case reloads).
  always_comb begin
    cand  = '0;
    sel   = DEF_IDX;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      w_eff[i] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      if (w_eff[i] == '0) w_eff[i] = WEIGHT_W'(1);
      cand[i] = Hreq[i] && (credit_q[i] != '0);
    end
    any_req  = |Hreq;
    any_cand = |cand;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      idx = hmaster_q + IDX_W'(k);
      if (!found && (any_cand ? cand[idx] : Hreq[idx])) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign reload  = handover && any_req && !any_cand;
  assign consume = acc_nonseq && ((hmaster_q != DEF_IDX) || Hreq[DEFAULT_MASTER]);

  always_comb begin
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      credit_d[i] = reload ? w_eff[i] : credit_q[i];
      if (consume && (hmaster_q == IDX_W'(i)) && (credit_d[i] != '0))
        credit_d[i] = credit_d[i] - WEIGHT_W'(1);
    end
  end

  always_comb begin
    hgrant_d       = hgrant_q;
    gnt_idx_d      = gnt_idx_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;
    if (handover) begin
      gnt_idx_d      = sel;
      hgrant_d       = '0;
      hgrant_d[sel]  = 1'b1;
    end
    if (Hready) begin
      hmaster_d      = gnt_idx_q;
      hmaster_data_d = hmaster_q;
      hmastlock_d    = Hlock[gnt_idx_q];
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q        <= BUS_IDLE;
      cnt_q          <= '0;
      credit_q       <= '0;
      hgrant_q       <= GNT_RST;
      gnt_idx_q      <= DEF_IDX;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      credit_q       <= credit_d;
      hgrant_q       <= hgrant_d;
      gnt_idx_q      <= gnt_idx_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
    end
  end

  assign Hgrant       = hgrant_q;
  assign Hmaster      = hmaster_q;
  assign Hmaster_data = hmaster_data_q;
  assign Hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// Scoreboard bench for ahb_wrr_arbiter: expected grant/owner/lock values are
// queued as stimulus is driven and compared one cycle later.
module tb_ahb_wrr_arbiter;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam int K_GRANT = 0, K_MASTER = 1, K_DATA = 2, K_LOCK = 3, K_CREDIT2 = 4;

  logic        Hclk, Hresetn, Hready, Hmastlock;
  logic [3:0]  Hreq, Hlock, Hgrant;
  logic [1:0]  Htrans, Hmaster, Hmaster_data;
  logic [2:0]  Hburst;
  logic [15:0] cfg_weight;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] val;
  } sb_t;

  sb_t  exp_q[$];
  int   own_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ahb_wrr_arbiter #(.N_MASTERS(4), .WEIGHT_W(4), .DEFAULT_MASTER(0)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock),
    .Hready(Hready), .Htrans(Htrans), .Hburst(Hburst), .cfg_weight(cfg_weight),
    .Hgrant(Hgrant), .Hmaster(Hmaster), .Hmaster_data(Hmaster_data),
    .Hmastlock(Hmastlock)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_GRANT:  return {4'b0, Hgrant};
      K_MASTER: return {6'b0, Hmaster};
      K_DATA:   return {6'b0, Hmaster_data};
      K_LOCK:   return {7'b0, Hmastlock};
      default:  return {4'b0, dut.credit_q[2]};
    endcase
  endfunction

  task automatic sb_push(input string tag, input int kind, input logic [7:0] val);
    sb_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0; Hreq = '0; Hlock = '0; Hready = 1'b1;
    Htrans = TR_IDLE; Hburst = 3'b000;
    repeat (2) tick();
    Hresetn = 1'b1;
  endtask

  task automatic wait_owner(input logic [1:0] m);
    int cyc = 0;
    while (!(Hmaster == m && Hgrant == (4'b1 << m)) && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!(Hmaster == m && Hgrant == (4'b1 << m)))
      chk("wait_owner", {Hgrant, 2'b0, Hmaster}, {4'b1 << m, 2'b0, m});
  endtask

  // Each granted owner issues one SINGLE NONSEQ per tenure; owners are compared
  // against the queued expected order, data-phase owner one edge later.
  task automatic run_tenures(input int budget);
    logic prev_ns = 1'b0;
    int   cyc = 0;
    int   exp_m;
    while (own_q.size() > 0 && cyc < budget) begin
      if (Hgrant == (4'b1 << Hmaster) && !prev_ns) begin
        exp_m = own_q.pop_front();
        chk("owner", {6'b0, Hmaster}, 8'(exp_m));
        Htrans = TR_NONSEQ; Hburst = 3'b000; prev_ns = 1'b1;
        sb_push("dphase", K_DATA, 8'(exp_m));
      end else begin
        Htrans = TR_IDLE; prev_ns = 1'b0;
      end
      tick();
      sb_drain();
      cyc++;
    end
    Htrans = TR_IDLE;
    if (own_q.size() != 0) chk("tenure_timeout", 8'(own_q.size()), 8'd0);
    own_q.delete();
  endtask

  initial begin
    cfg_weight = 16'h1111;

    // Reset state and idle hold with no requesters.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb_push("rst_grant", K_GRANT, 8'h01);
      sb_push("rst_master", K_MASTER, 8'h00);
      sb_push("rst_lock", K_LOCK, 8'h00);
      tick();
      sb_drain();
    end

    // Equal weights, everyone requesting.
    do_reset();
    cfg_weight = 16'h1111; Hreq = 4'hF;
    own_q = '{0, 1, 2, 3, 0};
    run_tenures(60);

    // Weights M0=3, others 0 (treated as 1); only M0/M1 request.
    do_reset();
    cfg_weight = 16'h0003; Hreq = 4'b0011;
    own_q = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
    run_tenures(80);

    // M1 INCR8 with a two-cycle wait state; Hreq[1] drops mid-burst.
    do_reset();
    cfg_weight = 16'h1111; Hreq = 4'b0010;
    wait_owner(2'd1);
    Hreq = 4'hF; Htrans = TR_NONSEQ; Hburst = 3'b101;
    sb_push("b8_first", K_GRANT, 8'h02);
    tick(); sb_drain();
    for (int b = 2; b <= 8; b++) begin
      if (b == 4) Hreq = 4'b1101;
      if (b == 5) begin
        Hready = 1'b0; Htrans = TR_SEQ;
        repeat (2) begin
          sb_push("b8_wait", K_GRANT, 8'h02);
          tick(); sb_drain();
        end
        Hready = 1'b1;
      end
      Htrans = TR_SEQ;
      sb_push(b == 8 ? "b8_last" : "b8_beat", K_GRANT, b == 8 ? 8'h04 : 8'h02);
      tick(); sb_drain();
    end
    Htrans = TR_IDLE;
    sb_push("b8_next_master", K_MASTER, 8'h02);
    sb_push("b8_next_grant", K_GRANT, 8'h04);
    tick(); sb_drain();

    // M2 undefined-length INCR, Hreq drops after five beats.
    do_reset();
    cfg_weight = 16'h1311; Hreq = 4'b0100;
    wait_owner(2'd2);
    sb_push("incr_credit_pre", K_CREDIT2, 8'h03);
    sb_drain();
    Htrans = TR_NONSEQ; Hburst = 3'b001;
    for (int b = 1; b <= 5; b++) begin
      if (b > 1) Htrans = TR_SEQ;
      sb_push("incr_beat", K_GRANT, 8'h04);
      tick(); sb_drain();
    end
    Hreq = 4'b1011; Htrans = TR_IDLE;
    sb_push("incr_drop_grant", K_GRANT, 8'h08);
    sb_push("incr_credit_post", K_CREDIT2, 8'h02);
    tick(); sb_drain();

    // M3 locked sequence, then release.
    do_reset();
    cfg_weight = 16'h1111; Hreq = 4'b1000; Hlock = 4'b1000;
    wait_owner(2'd3);
    sb_push("lock_pre", K_LOCK, 8'h01);
    sb_drain();
    Hreq = 4'hF; Htrans = TR_NONSEQ; Hburst = 3'b000;
    sb_push("lock_grant", K_GRANT, 8'h08);
    sb_push("lock_flag", K_LOCK, 8'h01);
    tick(); sb_drain();
    Htrans = TR_IDLE;
    for (int i = 0; i < 4; i++) begin
      sb_push("lock_hold_grant", K_GRANT, 8'h08);
      sb_push("lock_hold_flag", K_LOCK, 8'h01);
      tick(); sb_drain();
    end
    Hlock = 4'b0000;
    sb_push("unlock_grant", K_GRANT, 8'h08);
    sb_push("unlock_flag", K_LOCK, 8'h00);
    tick(); sb_drain();
    sb_push("unlock_handover", K_GRANT, 8'h01);
    tick(); sb_drain();

    // Asynchronous reset while locked.
    do_reset();
    Hreq = 4'b1000; Hlock = 4'b1000;
    wait_owner(2'd3);
    Hreq = 4'hF; Htrans = TR_NONSEQ;
    tick();
    Htrans = TR_IDLE;
    sb_push("lock2_grant", K_GRANT, 8'h08);
    sb_push("lock2_flag", K_LOCK, 8'h01);
    tick(); sb_drain();
    #2 Hresetn = 1'b0;
    #1;
    sb_push("arst_grant", K_GRANT, 8'h01);
    sb_push("arst_lock", K_LOCK, 8'h00);
    sb_push("arst_master", K_MASTER, 8'h00);
    sb_drain();
    #2 Hresetn = 1'b1;
    Hreq = '0; Hlock = '0;
    tick();

    if (exp_q.size() != 0) chk("sb_leftover", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
